// File: rtl/trig_burst_capture_pkg.sv
// Shared types and helpers for the triggered burst-capture block.
package trig_burst_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W = 16;

  // Pointer width carries one extra bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trig_burst_capture_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo
  import trig_burst_capture_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [WIDTH-1:0]        i_wdata,
  output logic [WIDTH-1:0]        o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [ptr_w(DEPTH)-1:0] o_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;
  logic [PW-1:0]    w_count;

  // Occupancy and handshake qualification.
  always_comb begin
    w_count   = r_wr_ptr - r_rd_ptr;
    o_full    = (w_count == PW'(DEPTH));
    o_empty   = (w_count == {PW{1'b0}});
    w_do_pop  = i_pop & ~o_empty;
    w_do_push = i_push & (~o_full | w_do_pop);
    o_count   = w_count;
    o_rdata   = r_mem[r_rd_ptr[AW-1:0]];
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  // Read/write pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/trig_burst_capture.sv
// Captures a decimated burst of ADC words per accepted trigger and streams it out
// through a small FIFO, flagging the last word, completion and any dropped samples.
module trig_burst_capture
  import trig_burst_capture_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int NUM_SAMPLES = 256,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic              sclock,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic [7:0]        decim,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int          PW       = ptr_w(FIFO_DEPTH);
  localparam logic [15:0] LAST_IDX = 16'(NUM_SAMPLES - 1);

  state_t          r_state;
  logic [7:0]      r_decim_q;
  logic [7:0]      r_decim_cnt;
  logic [15:0]     r_sample_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_overflow;

  logic            w_tick;
  logic            w_last;
  logic            w_pop;
  logic            w_drop;
  logic            w_drain_empty;
  logic            w_full;
  logic            w_empty;
  logic [PW-1:0]   w_count;
  logic [DATA_W:0] w_rdata;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (sclock),
    .i_rst_n (rst_n),
    .i_push  (w_tick),
    .i_pop   (w_pop),
    .i_wdata ({w_last, adc_data}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Sample tick, drop detection and the drain-complete condition.
  always_comb begin
    out_valid     = ~w_empty;
    out_data      = w_rdata[DATA_W-1:0];
    out_last      = w_rdata[DATA_W];
    w_pop         = out_valid & out_ready;
    w_tick        = (r_state == ST_CAPTURE) && (r_decim_cnt == 8'd0);
    w_last        = (r_sample_cnt == LAST_IDX);
    w_drop        = w_tick & w_full & ~w_pop;
    w_drain_empty = (w_count == {PW{1'b0}}) || ((w_count == PW'(1)) && w_pop);
  end

  // Burst FSM with its counters and status flags.
  always_ff @(posedge sclock or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_decim_q    <= 8'd0;
      r_decim_cnt  <= 8'd0;
      r_sample_cnt <= 16'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (trigger) begin
            r_state      <= ST_CAPTURE;
            r_busy       <= 1'b1;
            r_decim_q    <= decim;
            r_decim_cnt  <= 8'd0;
            r_sample_cnt <= 16'd0;
            r_overflow   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (w_tick) begin
            r_decim_cnt  <= r_decim_q;
            r_sample_cnt <= r_sample_cnt + 16'd1;
            if (w_drop) begin
              r_overflow <= 1'b1;
            end
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end else begin
            r_decim_cnt <= r_decim_cnt - 8'd1;
          end
        end
        ST_DRAIN: begin
          if (w_drain_empty) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_trig_burst_capture.sv
// Self-checking bench for trig_burst_capture: directed vector table, corner-case
// sequences and randomized traffic compared against a queue-based reference model.
module tb_trig_burst_capture;

  localparam int N = 8;
  localparam int DEPTH = 4;

  logic        sclock;
  logic        rst_n;
  logic        trigger;
  logic [7:0]  decim;
  logic [15:0] adc_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        overflow;

  trig_burst_capture #(
    .DATA_W      (16),
    .NUM_SAMPLES (N),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .sclock    (sclock),
    .rst_n     (rst_n),
    .trigger   (trigger),
    .decim     (decim),
    .adc_data  (adc_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  initial sclock = 1'b0;
  always #5 sclock = ~sclock;

  int n_pass = 0;
  int n_total = 0;
  bit ramp = 1'b1;

  // Reference model: burst phase, position inside the burst, and a word queue.
  int          m_state;
  int          m_cyc;
  int          m_d;
  bit          m_ovf;
  bit          m_done;
  logic [16:0] m_q[$];
  logic [16:0] got[$];

  typedef struct {
    logic        trig;
    logic [7:0]  dec;
    logic        rdy;
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic        bsy;
    logic        dn;
    logic        ovf;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cyc   = 0;
    m_d     = 0;
    m_ovf   = 1'b0;
    m_done  = 1'b0;
    m_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_edge();
    bit pop;
    bit full0;
    bit is_last;
    bit nd;
    int k;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (out_valid && out_ready) got.push_back({out_last, out_data});
    pop   = (m_q.size() > 0) && out_ready;
    full0 = (m_q.size() >= DEPTH);
    if (pop) void'(m_q.pop_front());
    nd = 1'b0;
    case (m_state)
      0: begin
        if (trigger) begin
          m_state = 1;
          m_cyc   = 0;
          m_d     = int'(decim);
          m_ovf   = 1'b0;
        end
      end
      1: begin
        if (m_cyc % (m_d + 1) == 0) begin
          k       = m_cyc / (m_d + 1);
          is_last = (k == N - 1);
          if (!full0 || pop) m_q.push_back({is_last, adc_data});
          else m_ovf = 1'b1;
          if (is_last) m_state = 2;
        end
        m_cyc++;
      end
      default: begin
        if (m_q.size() == 0) begin
          m_state = 0;
          nd      = 1'b1;
        end
      end
    endcase
    m_done = nd;
  endtask

  task automatic model_compare();
    chk("valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("data", out_data, m_q[0][15:0]);
      chk("last", out_last, m_q[0][16]);
    end
    chk("busy", busy, m_state != 0);
    chk("done", done, m_done);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic step();
    model_edge();
    @(posedge sclock);
    #1;
    model_compare();
    if (ramp) adc_data = adc_data + 16'd1;
    else adc_data = 16'($urandom);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until busy drops (the done cycle), bounded by a cycle budget.
  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      step();
      c++;
    end
    chk({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  initial begin
    logic [15:0] t0;

    rst_n     = 1'b0;
    trigger   = 1'b0;
    decim     = 8'd0;
    adc_data  = 16'd0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge sclock);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    steps(2);

    // Directed burst table: decim=0, ready=1, adc ramp equal to vector index.
    vt[0] = '{1'b1, 8'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 1; i <= 8; i++)
      vt[i] = '{1'b0, 8'd0, 1'b1, 1'b1, 16'(i), (i == 8), 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 8'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      trigger   = vt[i].trig;
      decim     = vt[i].dec;
      out_ready = vt[i].rdy;
      adc_data  = 16'(i);
      step();
      chk("tbl_valid", out_valid, vt[i].valid);
      if (vt[i].valid) begin
        chk("tbl_data", out_data, vt[i].data);
        chk("tbl_last", out_last, vt[i].last);
      end
      chk("tbl_busy", busy, vt[i].bsy);
      chk("tbl_done", done, vt[i].dn);
      chk("tbl_overflow", overflow, vt[i].ovf);
    end
    trigger = 1'b0;

    // Decimation by 4; decim changed mid-burst must not matter.
    got.delete();
    decim    = 8'd3;
    trigger  = 1'b1;
    adc_data = 16'd100;
    t0       = adc_data;
    step();
    trigger = 1'b0;
    decim   = 8'd0;
    wait_idle("decim", 200);
    chk("decim_count", got.size(), N);
    if (got.size() == N) begin
      chk("decim_first", got[0][15:0], t0 + 16'd1);
      for (int i = 1; i < N; i++)
        chk("decim_spacing", got[i][15:0] - got[i-1][15:0], 16'd4);
      chk("decim_last_flag", got[N-1][16], 1'b1);
      chk("decim_not_last", got[N-2][16], 1'b0);
    end
    step();

    // Backpressure: 4 kept, 4 dropped, final word not marked last.
    got.delete();
    out_ready = 1'b0;
    trigger   = 1'b1;
    step();
    trigger = 1'b0;
    steps(N);
    chk("bp_overflow", overflow, 1'b1);
    chk("bp_busy_drain", busy, 1'b1);
    chk("bp_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    wait_idle("bp", 50);
    chk("bp_done", done, 1'b1);
    chk("bp_words", got.size(), DEPTH);
    if (got.size() == DEPTH) begin
      chk("bp_tail_last", got[DEPTH-1][16], 1'b0);
      chk("bp_order", got[DEPTH-1][15:0] - got[0][15:0], 16'(DEPTH - 1));
    end
    step();
    chk("bp_done_pulse", done, 1'b0);
    chk("bp_ovf_sticky", overflow, 1'b1);

    // Second trigger mid-capture ignored; trigger coincident with done accepted.
    got.delete();
    decim   = 8'd1;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    steps(3);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    wait_idle("ign", 100);
    chk("ign_words", got.size(), N);
    chk("ign_done", done, 1'b1);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("retrig_busy", busy, 1'b1);
    wait_idle("retrig", 100);
    chk("retrig_words", got.size(), 2 * N);
    step();

    // Reset mid-capture with 3 words buffered.
    out_ready = 1'b0;
    decim     = 8'd0;
    trigger   = 1'b1;
    step();
    trigger = 1'b0;
    steps(3);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_overflow", overflow, 1'b0);
    chk("arst_done", done, 1'b0);
    model_reset();
    steps(2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    steps(4);
    chk("post_rst_valid", out_valid, 1'b0);

    // Randomized traffic against the model.
    ramp = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      trigger   = ($urandom_range(0, 15) == 0);
      decim     = 8'($urandom_range(0, 3));
      out_ready = (i % 400 < 120) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
